// File: rtl/draw_text_pages.sv
// Text-overlay stage: draws one of N_PAGES text pages over the incoming VGA stream, with a
// key-driven menu cursor and page switches that only take effect at the start of vblank.
module draw_text_pages #(
  parameter int unsigned N_PAGES    = 4,
  parameter int unsigned COLS       = 64,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned POS_X      = 230,
  parameter int unsigned POS_Y      = 300,
  parameter int unsigned SCALE      = 0,
  parameter int unsigned FONT_LAT   = 2,
  parameter logic [11:0] TEXT_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter logic [11:0] HL_COLOR   = 12'h00F,
  parameter logic [3:0]  KEY_IDLE   = 4'h0,
  parameter logic [3:0]  KEY_UP     = 4'h1,
  parameter logic [3:0]  KEY_DOWN   = 4'h2,
  parameter logic [3:0]  KEY_ENTER  = 4'h3,
  parameter logic [3:0]  KEY_ESC    = 4'hF,
  localparam int unsigned ColW      = $clog2(COLS),
  localparam int unsigned RowW      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned PageW     = $clog2(N_PAGES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key_i,
  input  logic [10:0]      in_hcount_i,
  input  logic [10:0]      in_vcount_i,
  input  logic             in_hsync_i,
  input  logic             in_vsync_i,
  input  logic             in_hblnk_i,
  input  logic             in_vblnk_i,
  input  logic [11:0]      in_rgb_i,
  output logic [10:0]      out_hcount_o,
  output logic [10:0]      out_vcount_o,
  output logic             out_hsync_o,
  output logic             out_vsync_o,
  output logic             out_hblnk_o,
  output logic             out_vblnk_o,
  output logic [11:0]      out_rgb_o,
  input  logic [7:0]       char_line_pixels_i,
  output logic [ColW-1:0]  char_col_o,
  output logic [RowW-1:0]  char_row_o,
  output logic [3:0]       char_line_o,
  output logic [PageW-1:0] page_sel_o,
  output logic [RowW-1:0]  cursor_o
);

  localparam int unsigned BoxW = (COLS * 8) << SCALE;
  localparam int unsigned BoxH = (ROWS * 16) << SCALE;
  localparam int unsigned Dly  = FONT_LAT + 1;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  typedef struct packed {
    vga_t            vga;
    logic            box;
    logic [2:0]      px;
    logic [RowW-1:0] row;
  } pix_t;

  // ---------------------------------------------------------------- key / page control
  logic [3:0]       key_prev_q;
  logic             vblnk_prev_q;
  logic             key_fire;
  logic [RowW-1:0]  cursor_q, cursor_d;
  logic [PageW-1:0] page_q, page_d;
  logic [PageW-1:0] pend_q, pend_d;

  assign key_fire = (key_i != key_prev_q) && (key_i != KEY_IDLE);

  always_comb begin
    cursor_d = cursor_q;
    pend_d   = pend_q;
    page_d   = (in_vblnk_i && !vblnk_prev_q) ? pend_q : page_q;
    if (key_fire) begin
      if (page_q == '0) begin
        case (key_i)
          KEY_UP:    cursor_d = (cursor_q == '0) ? RowW'(ROWS - 1) : cursor_q - RowW'(1);
          KEY_DOWN:  cursor_d = (cursor_q == RowW'(ROWS - 1)) ? '0 : cursor_q + RowW'(1);
          KEY_ENTER: begin
            // Menu row k-1 opens page k; rows with no page behind them do nothing.
            if (32'(cursor_q) + 1 < N_PAGES) pend_d = PageW'(32'(cursor_q) + 1);
          end
          default: ;
        endcase
      end else if (key_i == KEY_ESC) begin
        pend_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_q   <= KEY_IDLE;
      vblnk_prev_q <= 1'b0;
      cursor_q     <= '0;
      page_q       <= '0;
      pend_q       <= '0;
    end else begin
      key_prev_q   <= key_i;
      vblnk_prev_q <= in_vblnk_i;
      cursor_q     <= cursor_d;
      page_q       <= page_d;
      pend_q       <= pend_d;
    end
  end

  // ---------------------------------------------------------------- stage 1: font address
  logic            in_box;
  logic [10:0]     dx, dy, dxs, dys;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [3:0]      line_q, line_d;

  assign in_box = (32'(in_hcount_i) >= POS_X) && (32'(in_hcount_i) < POS_X + BoxW) &&
                  (32'(in_vcount_i) >= POS_Y) && (32'(in_vcount_i) < POS_Y + BoxH);
  assign dx  = in_hcount_i - 11'(POS_X);
  assign dy  = in_vcount_i - 11'(POS_Y);
  assign dxs = dx >> SCALE;
  assign dys = dy >> SCALE;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    line_d = line_q;
    if (in_box) begin
      col_d  = ColW'(dxs >> 3);
      row_d  = RowW'(dys >> 4);
      line_d = dys[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      line_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      line_q <= line_d;
    end
  end

  // ---------------------------------------------------------------- delay line
  // Carries timing plus the per-pixel glyph context until the font data has arrived.
  pix_t stage_in;
  pix_t dly_q [Dly];
  pix_t last;

  always_comb begin
    stage_in.vga.hcount = in_hcount_i;
    stage_in.vga.vcount = in_vcount_i;
    stage_in.vga.hsync  = in_hsync_i;
    stage_in.vga.vsync  = in_vsync_i;
    stage_in.vga.hblnk  = in_hblnk_i;
    stage_in.vga.vblnk  = in_vblnk_i;
    stage_in.vga.rgb    = in_rgb_i;
    stage_in.box        = in_box;
    stage_in.px         = dxs[2:0];
    stage_in.row        = RowW'(dys >> 4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Dly); i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= stage_in;
      for (int i = 1; i < int'(Dly); i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign last = dly_q[Dly-1];

  // ---------------------------------------------------------------- colour + output stage
  vga_t out_q, out_d;
  logic glyph_bit;

  assign glyph_bit = char_line_pixels_i[3'd7 - last.px];

  always_comb begin
    out_d = last.vga;
    if (last.box) begin
      if (glyph_bit)                                     out_d.rgb = TEXT_COLOR;
      else if ((page_q == '0) && (last.row == cursor_q)) out_d.rgb = HL_COLOR;
      else                                               out_d.rgb = BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out_hcount_o = out_q.hcount;
  assign out_vcount_o = out_q.vcount;
  assign out_hsync_o  = out_q.hsync;
  assign out_vsync_o  = out_q.vsync;
  assign out_hblnk_o  = out_q.hblnk;
  assign out_vblnk_o  = out_q.vblnk;
  assign out_rgb_o    = out_q.rgb;
  assign char_col_o   = col_q;
  assign char_row_o   = row_q;
  assign char_line_o  = line_q;
  assign page_sel_o   = page_q;
  assign cursor_o     = cursor_q;

endmodule

// File: tb/tb_draw_text_pages.sv
// Bench for draw_text_pages: three instances (default, SCALE=1/N_PAGES=2/FONT_LAT=1,
// FONT_LAT=3) share one stimulus; each has its own font ROM model of matching latency.
module tb_draw_text_pages;

  localparam int PX = 230;
  localparam int PY = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  key = 4'h0;
  logic [10:0] h = '0, v = '0;
  logic        hs = 1'b0, vs = 1'b0, hb = 1'b0, vb = 1'b0;
  logic [11:0] rgb = '0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          font_mode = 0;
  logic [7:0]  font_konst = 8'h00;

  // Instance outputs
  logic [10:0] a_hc, a_vc, b_hc, b_vc, c_hc, c_vc;
  logic        a_hs, a_vs, a_hb, a_vb, b_hs, b_vs, b_hb, b_vb, c_hs, c_vs, c_hb, c_vb;
  logic [11:0] a_rgb, b_rgb, c_rgb;
  logic [7:0]  a_pix, b_pix, c_pix;
  logic [5:0]  a_col, b_col, c_col;
  logic [1:0]  a_row, b_row, c_row, a_cur, b_cur, c_cur, a_page, c_page;
  logic [3:0]  a_line, b_line, c_line;
  logic [0:0]  b_page;

  draw_text_pages u_a (
    .clk(clk), .rst_n(rst_n), .key_i(key),
    .in_hcount_i(h), .in_vcount_i(v), .in_hsync_i(hs), .in_vsync_i(vs),
    .in_hblnk_i(hb), .in_vblnk_i(vb), .in_rgb_i(rgb),
    .out_hcount_o(a_hc), .out_vcount_o(a_vc), .out_hsync_o(a_hs), .out_vsync_o(a_vs),
    .out_hblnk_o(a_hb), .out_vblnk_o(a_vb), .out_rgb_o(a_rgb),
    .char_line_pixels_i(a_pix), .char_col_o(a_col), .char_row_o(a_row),
    .char_line_o(a_line), .page_sel_o(a_page), .cursor_o(a_cur)
  );

  draw_text_pages #(.N_PAGES(2), .SCALE(1), .FONT_LAT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .key_i(key),
    .in_hcount_i(h), .in_vcount_i(v), .in_hsync_i(hs), .in_vsync_i(vs),
    .in_hblnk_i(hb), .in_vblnk_i(vb), .in_rgb_i(rgb),
    .out_hcount_o(b_hc), .out_vcount_o(b_vc), .out_hsync_o(b_hs), .out_vsync_o(b_vs),
    .out_hblnk_o(b_hb), .out_vblnk_o(b_vb), .out_rgb_o(b_rgb),
    .char_line_pixels_i(b_pix), .char_col_o(b_col), .char_row_o(b_row),
    .char_line_o(b_line), .page_sel_o(b_page), .cursor_o(b_cur)
  );

  draw_text_pages #(.FONT_LAT(3)) u_c (
    .clk(clk), .rst_n(rst_n), .key_i(key),
    .in_hcount_i(h), .in_vcount_i(v), .in_hsync_i(hs), .in_vsync_i(vs),
    .in_hblnk_i(hb), .in_vblnk_i(vb), .in_rgb_i(rgb),
    .out_hcount_o(c_hc), .out_vcount_o(c_vc), .out_hsync_o(c_hs), .out_vsync_o(c_vs),
    .out_hblnk_o(c_hb), .out_vblnk_o(c_vb), .out_rgb_o(c_rgb),
    .char_line_pixels_i(c_pix), .char_col_o(c_col), .char_row_o(c_row),
    .char_line_o(c_line), .page_sel_o(c_page), .cursor_o(c_cur)
  );

  // Font ROM: constant byte, or a byte that differs per column/line/row/page
  function automatic logic [7:0] font_fn(int mode, logic [7:0] konst, int page, int row,
                                         int col, int line);
    if (mode == 0) return konst;
    return 8'(col * 37 + line * 3 + row * 11 + page * 7 + 5);
  endfunction

  logic [7:0] fa_q [2] = '{8'h00, 8'h00};
  logic [7:0] fb_q     = 8'h00;
  logic [7:0] fc_q [3] = '{8'h00, 8'h00, 8'h00};

  always @(posedge clk) begin
    fa_q[0] <= font_fn(font_mode, font_konst, int'(a_page), int'(a_row), int'(a_col),
                       int'(a_line));
    fa_q[1] <= fa_q[0];
    fb_q    <= font_fn(font_mode, font_konst, int'(b_page), int'(b_row), int'(b_col),
                       int'(b_line));
    fc_q[0] <= font_fn(font_mode, font_konst, int'(c_page), int'(c_row), int'(c_col),
                       int'(c_line));
    fc_q[1] <= fc_q[0];
    fc_q[2] <= fc_q[1];
  end

  assign a_pix = fa_q[1];
  assign b_pix = fb_q;
  assign c_pix = fc_q[2];

  // Expected pixel colour for one input sample on a COLS=64, ROWS=4 instance
  function automatic logic [11:0] exp_rgb(int hh, int vv, logic [11:0] irgb, int scale,
                                          int page, int cur, int mode, logic [7:0] konst);
    int dx, dy;
    logic [7:0] b;
    if (hh < PX || hh >= PX + (512 << scale) || vv < PY || vv >= PY + (64 << scale))
      return irgb;
    dx = (hh - PX) >> scale;
    dy = (vv - PY) >> scale;
    b  = font_fn(mode, konst, page, dy / 16, dx / 8, dy % 16);
    if (b[7 - (dx % 8)]) return 12'hFFF;
    if (page == 0 && (dy / 16) == cur) return 12'h00F;
    return 12'h000;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_px(int hh, int vv, logic [11:0] c);
    h   = 11'(hh);
    v   = 11'(vv);
    rgb = c;
    hs  = h[0];
  endtask

  task automatic press(logic [3:0] k, int hold);
    key = k;
    repeat (hold) step();
    key = 4'h0;
    repeat (2) step();
  endtask

  // Sweep hcount along one line; every instance must reproduce each sample exactly
  // FONT_LAT+2 cycles later, with glyph bits taken from that sample's own column.
  task automatic stream(int h0, int vv, int n, int cur);
    int          hh [64];
    logic [11:0] cc [64];
    for (int i = 0; i < n; i++) begin
      if (i >= 3) begin
        check("b_lat_hcount", 32'(b_hc), 32'(hh[i-3]));
        check("b_glyph_rgb", 32'(b_rgb), 32'(exp_rgb(hh[i-3], vv, cc[i-3], 1, 0, cur, 1, 8'h00)));
      end
      if (i >= 4) begin
        check("a_lat_hcount", 32'(a_hc), 32'(hh[i-4]));
        check("a_lat_vcount", 32'(a_vc), 32'(vv));
        check("a_lat_hsync", 32'(a_hs), 32'(hh[i-4] & 1));
        check("a_glyph_rgb", 32'(a_rgb), 32'(exp_rgb(hh[i-4], vv, cc[i-4], 0, 0, cur, 1, 8'h00)));
      end
      if (i >= 5) begin
        check("c_lat_hcount", 32'(c_hc), 32'(hh[i-5]));
        check("c_glyph_rgb", 32'(c_rgb), 32'(exp_rgb(hh[i-5], vv, cc[i-5], 0, 0, cur, 1, 8'h00)));
      end
      hh[i] = h0 + i;
      cc[i] = 12'(i * 291 + 1);
      drive_px(hh[i], vv, cc[i]);
      step();
    end
  endtask

  typedef struct packed {
    logic [10:0] hh;
    logic [10:0] vv;
    logic [11:0] c;
    logic [7:0]  k;
    logic [11:0] ea;    // expected rgb, SCALE=0 instances
    logic [11:0] eb;    // expected rgb, SCALE=1 instance
    logic [5:0]  cola;
    logic [5:0]  colb;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{11'd230, 11'd300, 12'h0F0, 8'h80, 12'hFFF, 12'hFFF, 6'd0,  6'd0};
    tbl[1]  = '{11'd230, 11'd300, 12'h0F0, 8'h00, 12'h00F, 12'h00F, 6'd0,  6'd0};
    tbl[2]  = '{11'd229, 11'd300, 12'h0F0, 8'h80, 12'h0F0, 12'h0F0, 6'd0,  6'd0};
    tbl[3]  = '{11'd230, 11'd299, 12'h0F0, 8'hFF, 12'h0F0, 12'h0F0, 6'd0,  6'd0};
    tbl[4]  = '{11'd231, 11'd300, 12'h123, 8'h40, 12'hFFF, 12'h00F, 6'd0,  6'd0};
    tbl[5]  = '{11'd231, 11'd300, 12'h123, 8'h80, 12'h00F, 12'hFFF, 6'd0,  6'd0};
    tbl[6]  = '{11'd230, 11'd316, 12'h0F0, 8'h00, 12'h000, 12'h00F, 6'd0,  6'd0};
    tbl[7]  = '{11'd741, 11'd363, 12'h0F0, 8'h01, 12'hFFF, 12'hFFF, 6'd63, 6'd31};
    tbl[8]  = '{11'd742, 11'd363, 12'h0F0, 8'h01, 12'h0F0, 12'h000, 6'd63, 6'd32};
    tbl[9]  = '{11'd741, 11'd364, 12'h0AA, 8'h01, 12'h0AA, 12'hFFF, 6'd63, 6'd31};
    tbl[10] = '{11'd245, 11'd300, 12'h0F0, 8'h01, 12'hFFF, 12'hFFF, 6'd1,  6'd0};
    tbl[11] = '{11'd246, 11'd300, 12'h0F0, 8'h80, 12'hFFF, 12'hFFF, 6'd2,  6'd1};
    tbl[12] = '{11'd246, 11'd300, 12'h0F0, 8'h01, 12'h00F, 12'h00F, 6'd2,  6'd1};

    // Reset with live input
    drive_px(500, 305, 12'hABC);
    vs = 1'b1;
    hb = 1'b1;
    repeat (6) step();
    check("rst_a_hcount", 32'(a_hc), 32'h0);
    check("rst_a_vcount", 32'(a_vc), 32'h0);
    check("rst_a_rgb", 32'(a_rgb), 32'h0);
    check("rst_a_vsync", 32'(a_vs), 32'h0);
    check("rst_a_hblnk", 32'(a_hb), 32'h0);
    check("rst_a_page", 32'(a_page), 32'h0);
    check("rst_a_cursor", 32'(a_cur), 32'h0);
    check("rst_a_col", 32'(a_col), 32'h0);
    check("rst_b_hcount", 32'(b_hc), 32'h0);
    check("rst_c_rgb", 32'(c_rgb), 32'h0);
    vs = 1'b0;
    hb = 1'b0;

    // Release and sweep across the left edge of the box
    font_mode = 1;
    rst_n = 1'b1;
    stream(224, 305, 40, 0);

    // Table-driven single pixels with a constant font byte
    font_mode = 0;
    for (int i = 0; i < 13; i++) begin
      font_konst = tbl[i].k;
      drive_px(int'(tbl[i].hh), int'(tbl[i].vv), tbl[i].c);
      repeat (8) step();
      check($sformatf("vec%0d_a_rgb", i), 32'(a_rgb), 32'(tbl[i].ea));
      check($sformatf("vec%0d_b_rgb", i), 32'(b_rgb), 32'(tbl[i].eb));
      check($sformatf("vec%0d_c_rgb", i), 32'(c_rgb), 32'(tbl[i].ea));
      check($sformatf("vec%0d_a_col", i), 32'(a_col), 32'(tbl[i].cola));
      check($sformatf("vec%0d_b_col", i), 32'(b_col), 32'(tbl[i].colb));
    end

    // Cursor wrap and one action per press
    press(4'h2, 2); check("cur_down1", 32'(a_cur), 32'd1);
    press(4'h2, 2); check("cur_down2", 32'(a_cur), 32'd2);
    press(4'h2, 2); check("cur_down3", 32'(a_cur), 32'd3);
    press(4'h2, 2); check("cur_wrap0", 32'(a_cur), 32'd0);
    press(4'h1, 2); check("cur_up_wrap", 32'(a_cur), 32'd3);
    press(4'h2, 100); check("cur_held", 32'(a_cur), 32'd0);
    check("cur_held_b", 32'(b_cur), 32'd0);
    press(4'h2, 2); check("cur_one", 32'(a_cur), 32'd1);

    // ENTER on row 1 opens page 2, but only at the vblnk rise
    press(4'h3, 2);
    repeat (5) step();
    check("page_wait", 32'(a_page), 32'd0);
    vb = 1'b1;
    check("page_before_edge", 32'(a_page), 32'd0);
    step();
    check("page_switch", 32'(a_page), 32'd2);
    check("page_switch_c", 32'(c_page), 32'd2);
    check("page_b_ignored", 32'(b_page), 32'd0);
    repeat (3) step();
    vb = 1'b0;
    press(4'h2, 2);
    check("cur_kept_in_page", 32'(a_cur), 32'd1);
    press(4'hF, 2);
    repeat (4) step();
    check("esc_wait", 32'(a_page), 32'd2);
    vb = 1'b1;
    step();
    check("esc_switch", 32'(a_page), 32'd0);
    vb = 1'b0;

    // Two ENTERs before vblnk: the later one wins
    press(4'h3, 2);
    press(4'h2, 2);
    check("cur_two", 32'(a_cur), 32'd2);
    press(4'h3, 2);
    vb = 1'b1;
    step();
    check("last_wins", 32'(a_page), 32'd3);
    check("b_row2_enter", 32'(b_page), 32'd0);
    vb = 1'b0;

    // No highlight on the cursor row outside the menu
    font_konst = 8'h00;
    drive_px(230, 332, 12'h0F0);
    repeat (8) step();
    check("page_no_hl_a", 32'(a_rgb), 32'h000);
    check("page_no_hl_b", 32'(b_rgb), 32'h000);

    // Mid-frame reset: outputs clear at once, then refill
    drive_px(400, 305, 12'hABC);
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_hcount", 32'(a_hc), 32'h0);
    check("mid_rst_rgb", 32'(a_rgb), 32'h0);
    check("mid_rst_page", 32'(a_page), 32'h0);
    check("mid_rst_cursor", 32'(a_cur), 32'h0);
    check("mid_rst_b_hcount", 32'(b_hc), 32'h0);
    step();
    step();
    font_mode = 1;
    rst_n = 1'b1;
    stream(720, 320, 40, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
